// File: rtl/ptp_bridge_pkg.sv
// Shared types for the PTP bridge rx pipe.
//   tuple_map_S    : classifier tuple used as the TCAM lookup key
//   SEGMENT_INFO_S : per-beat packet framing (start/end of packet)
package ptp_bridge_pkg;

    typedef struct packed {
        logic [47:0] dmac;
        logic [15:0] ethertype;
        logic [7:0]  msg_type;
        logic [7:0]  domain;
    } tuple_map_S;

    typedef struct packed {
        logic sop;
        logic eop;
    } SEGMENT_INFO_S;

endpackage

// File: rtl/ptp_bridge_lu_fetch.sv
// ptp_bridge_lu_fetch
//
// Lookup-side reader of the PTP bridge rx pipe. It pops one tuple-map entry,
// issues one TCAM lookup with it and waits for the response. It then pops that
// packet's beats from the packet FIFO into an AXI-S style output register, with
// the lookup result attached to every beat.
//
// Optional feature macro: PTP_BRIDGE_LU_RSP_TIMEOUT_EN
//   Defined   : WAIT gives up after RSP_TIMEOUT cycles. The packet goes out
//               with result 0 and lu2egr_tuser_timeout=1. The late response
//               that follows is dropped.
//   Undefined : WAIT holds until a response arrives. lu2egr_tuser_timeout is 0.
//
// Ports
//   clk, rst                     : single clock, synchronous active-high reset
//   pars2lu_tcam_req_fifo_*      : show-ahead tuple-map FIFO (empty/head in, rd out)
//   pars2lu_fifo_empty/tdata/... : show-ahead packet FIFO head; lu2pars_fifo_rd pops
//   lu2tcam_req_* / tcam2lu_*    : TCAM request (valid/ready) and response pulse
//   lu2egr_* / egr2lu_tready     : egress stream with result/timeout sideband
//   lu_pkt_cnt                   : wrapping count of eop beats accepted by egress
module ptp_bridge_lu_fetch
    import ptp_bridge_pkg::*;
#(
    parameter int TDATA_WIDTH        = 512,
    parameter int USERMETADATA_WIDTH = 1,
    parameter int RESULT_WIDTH       = 32,
    parameter int RSP_TIMEOUT        = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pars2lu_tcam_req_fifo_empty,
    output logic                          lu2pars_tcam_req_fifo_rd,
    input  tuple_map_S                    pars2lu_tuser_tuple_map,
    input  logic                          pars2lu_fifo_empty,
    output logic                          lu2pars_fifo_rd,
    input  logic [TDATA_WIDTH-1:0]        pars2lu_tdata,
    input  logic [USERMETADATA_WIDTH-1:0] pars2lu_tuser_usermetadata,
    input  SEGMENT_INFO_S                 pars2lu_tuser_segment_info,
    output logic                          lu2tcam_req_valid,
    output tuple_map_S                    lu2tcam_req_key,
    input  logic                          tcam2lu_req_ready,
    input  logic                          tcam2lu_rsp_valid,
    input  logic [RESULT_WIDTH-1:0]       tcam2lu_rsp_result,
    output logic                          lu2egr_tvalid,
    output logic [TDATA_WIDTH-1:0]        lu2egr_tdata,
    output logic [USERMETADATA_WIDTH-1:0] lu2egr_tuser_usermetadata,
    output SEGMENT_INFO_S                 lu2egr_tuser_segment_info,
    output logic [RESULT_WIDTH-1:0]       lu2egr_tuser_result,
    output logic                          lu2egr_tuser_timeout,
    input  logic                          egr2lu_tready,
    output logic [31:0]                   lu_pkt_cnt
);

    // A zero timeout would expire before any response could be seen.
    if (RSP_TIMEOUT < 1) begin : g_bad_rsp_timeout
        $error("ptp_bridge_lu_fetch: RSP_TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PKT
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    tuple_map_S                    key_r;
    logic [RESULT_WIDTH-1:0]       result_r;
    logic                          tcam_rd;
    logic                          pkt_rd;
    logic                          rsp_take;
    logic                          tmo_fire;
    logic                          egr_eop_acc;

    logic                          vld_p0;
    logic [TDATA_WIDTH-1:0]        tdata_p0;
    logic [USERMETADATA_WIDTH-1:0] meta_p0;
    SEGMENT_INFO_S                 seg_p0;
    logic [RESULT_WIDTH-1:0]       result_p0;
    logic [31:0]                   pkt_cnt;

`ifdef PTP_BRIDGE_LU_RSP_TIMEOUT_EN
    localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_r;
    logic             tmo_p0;
    logic             late_pend;

    // While a timed-out lookup still owes a response, the next response
    // belongs to that lookup and must not be taken as the current one.
    assign rsp_take = (state == S_WAIT) & tcam2lu_rsp_valid & ~late_pend;
    // A response in the expiry cycle wins over the timeout.
    assign tmo_fire = (state == S_WAIT) & ~rsp_take &
                      (tmo_cnt == TMO_W'(RSP_TIMEOUT - 1));
`else
    assign rsp_take = (state == S_WAIT) & tcam2lu_rsp_valid;
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        tcam_rd   = 1'b0;
        pkt_rd    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!pars2lu_tcam_req_fifo_empty) begin
                    tcam_rd   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (tcam2lu_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_take || tmo_fire) begin
                    state_nxt = S_PKT;
                end
            end
            S_PKT: begin
                // Pop only when the output register is free or being drained.
                pkt_rd = ~pars2lu_fifo_empty & (~vld_p0 | egr2lu_tready);
                if (pkt_rd && pars2lu_tuser_segment_info.eop) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign egr_eop_acc = vld_p0 & egr2lu_tready & seg_p0.eop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            key_r    <= '0;
            result_r <= '0;
            pkt_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (tcam_rd) begin
                key_r <= pars2lu_tuser_tuple_map;
            end
            if (rsp_take) begin
                result_r <= tcam2lu_rsp_result;
            end else if (tmo_fire) begin
                result_r <= '0;
            end
            if (egr_eop_acc) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

    // ---- egress output stage (p0): loaded on each packet FIFO pop ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            tdata_p0  <= '0;
            meta_p0   <= '0;
            seg_p0    <= '0;
            result_p0 <= '0;
        end else begin
            if (pkt_rd) begin
                vld_p0    <= 1'b1;
                tdata_p0  <= pars2lu_tdata;
                meta_p0   <= pars2lu_tuser_usermetadata;
                seg_p0    <= pars2lu_tuser_segment_info;
                result_p0 <= result_r;
            end else if (egr2lu_tready) begin
                vld_p0 <= 1'b0;
            end
        end
    end

`ifdef PTP_BRIDGE_LU_RSP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= '0;
            tmo_r     <= 1'b0;
            tmo_p0    <= 1'b0;
            late_pend <= 1'b0;
        end else begin
            if ((state == S_WAIT) && !rsp_take && !tmo_fire) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (rsp_take) begin
                tmo_r <= 1'b0;
            end else if (tmo_fire) begin
                tmo_r <= 1'b1;
            end
            if (pkt_rd) begin
                tmo_p0 <= tmo_r;
            end
            // A new timeout re-arms the flag even if an older late response lands now.
            if (tmo_fire) begin
                late_pend <= 1'b1;
            end else if (tcam2lu_rsp_valid) begin
                late_pend <= 1'b0;
            end
        end
    end

    assign lu2egr_tuser_timeout = tmo_p0;
`else
    assign lu2egr_tuser_timeout = 1'b0;
`endif

    assign lu2pars_tcam_req_fifo_rd  = tcam_rd;
    assign lu2pars_fifo_rd           = pkt_rd;
    assign lu2tcam_req_valid         = (state == S_REQ);
    assign lu2tcam_req_key           = key_r;
    assign lu2egr_tvalid             = vld_p0;
    assign lu2egr_tdata              = tdata_p0;
    assign lu2egr_tuser_usermetadata = meta_p0;
    assign lu2egr_tuser_segment_info = seg_p0;
    assign lu2egr_tuser_result       = result_p0;
    assign lu_pkt_cnt                = pkt_cnt;

endmodule

// File: doc/ptp_bridge_lu_fetch.md
# ptp_bridge_lu_fetch

Lookup-side reader for the parser/classifier output of the PTP bridge rx pipe. It drains two show-ahead FIFOs on the parser side: the TCAM request (tuple map) FIFO and the aligned packet FIFO. For each packet it issues one TCAM lookup and waits for the result. It then streams the packet beats downstream on a ready/valid interface, with the lookup result attached. It sits between the parse/classify stage and the egress action/forwarding stage.

## Interface
Parameters:
- TDATA_WIDTH, 512, packet data width
- USERMETADATA_WIDTH, 1, pass-through user metadata width
- RESULT_WIDTH, 32, TCAM result width
- RSP_TIMEOUT, 255, cycles to wait for a TCAM response (only used with the timeout feature; must be ≥1)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- pars2lu_tcam_req_fifo_empty  in  1  tuple-map FIFO empty
- lu2pars_tcam_req_fifo_rd  out  1  tuple-map FIFO pop; head data is valid in the same cycle
- pars2lu_tuser_tuple_map  in  ptp_bridge_pkg::tuple_map_S  head of tuple-map FIFO
- pars2lu_fifo_empty  in  1  packet FIFO empty
- lu2pars_fifo_rd  out  1  packet FIFO pop; head beat is valid in the same cycle
- pars2lu_tdata  in  TDATA_WIDTH  head beat data
- pars2lu_tuser_usermetadata  in  USERMETADATA_WIDTH  head beat metadata
- pars2lu_tuser_segment_info  in  ptp_bridge_pkg::SEGMENT_INFO_S  head beat sop/eop
- lu2tcam_req_valid  out  1  lookup request valid
- lu2tcam_req_key  out  ptp_bridge_pkg::tuple_map_S  lookup key
- tcam2lu_req_ready  in  1  TCAM accepts request
- tcam2lu_rsp_valid  in  1  lookup response valid (1-cycle pulse)
- tcam2lu_rsp_result  in  RESULT_WIDTH  lookup result
- lu2egr_tvalid  out  1  egress beat valid
- lu2egr_tdata  out  TDATA_WIDTH  egress data
- lu2egr_tuser_usermetadata  out  USERMETADATA_WIDTH  egress metadata
- lu2egr_tuser_segment_info  out  ptp_bridge_pkg::SEGMENT_INFO_S  egress sop/eop
- lu2egr_tuser_result  out  RESULT_WIDTH  lookup result, held on every beat of the packet
- lu2egr_tuser_timeout  out  1  result is a timeout substitute (all-zero result)
- egr2lu_tready  in  1  egress ready
- lu_pkt_cnt  out  32  packets fully forwarded (eop beats accepted by egress), wrapping

## Operation
- FSM states:
  - IDLE: when tcam-req FIFO is non-empty, pulse lu2pars_tcam_req_fifo_rd for 1 cycle, capture pars2lu_tuser_tuple_map into key register, go to REQ.
  - REQ: lu2tcam_req_valid=1 with key held stable until tcam2lu_req_ready; on handshake go to WAIT.
  - WAIT: on tcam2lu_rsp_valid capture result, clear timeout flag, go to PKT.
  - PKT: pop packet beats into the output register. After the beat with eop is popped, go to IDLE.
- Packet pop rule: lu2pars_fifo_rd = (state==PKT) & ~pars2lu_fifo_empty & (~lu2egr_tvalid | egr2lu_tready).
- Output register loads data/metadata/segment_info on each pop. Result and timeout come from the capture register.
- Exactly one lookup per packet. Tuple-map entries and packets pair in FIFO order.
- A beat without sop at packet start is forwarded unchanged. There is no resync.
- lu_pkt_cnt increments on lu2egr_tvalid & egr2lu_tready & eop.

## Timing
- Reset values: every output deasserts/clears to 0 (FSM→IDLE, lu_pkt_cnt=0, late-pending flag=0).
- FIFO pops are combinational from registered state and the empty inputs. No pop is ever issued while the FIFO is empty.
- Minimum latency, tcam-req FIFO non-empty to first egress beat valid: 1 (IDLE) + 1 (REQ, ready=1) + response latency + 1 pop cycle.
- Egress is AXI-S style. Data is held stable while tvalid & ~tready. Throughput is 1 beat/cycle with tready high. A single-beat packet (sop&eop) is legal.
- Response arriving in REQ (before the request handshake) is ignored.
- Reset mid-packet: FSM aborts immediately. Popped beats are lost. Upstream FIFOs are reset by the same rst.
- rst has priority over all events in the same cycle.

## Configuration
- PTP_BRIDGE_LU_RSP_TIMEOUT_EN defined:
  - WAIT runs a counter of width $clog2(RSP_TIMEOUT+1).
  - When the counter reaches RSP_TIMEOUT cycles with no response: result=0, lu2egr_tuser_timeout=1, set late-pending, go to PKT.
  - While late-pending, the next tcam2lu_rsp_valid in any state is discarded and clears the flag.
  - A response in the same cycle the timeout expires wins: it is captured, and no timeout is flagged.
- Not defined: WAIT holds indefinitely, lu2egr_tuser_timeout is tied 0, and there is no counter logic.

## Test plan
- One 3-beat packet, tuple-map key K, response 0xA5A5_0001 after 4 cycles, tready=1 → one request with key K; three egress beats with result 0xA5A5_0001; lu_pkt_cnt=1.
- Two back-to-back packets (1 beat, 2 beats), distinct keys/results → results pair in order; exactly 2 requests; lu_pkt_cnt=2.
- tcam2lu_req_ready low for 10 cycles → key held stable, no packet pop until the handshake and the response.
- egr2lu_tready toggling 1010… during a 4-beat packet → no beat lost or duplicated; data stable during stalls.
- Timeout enabled, RSP_TIMEOUT=8, no response → packet forwarded after 8 cycles in WAIT with result 0 and timeout=1. Late response at cycle 12 is discarded. The next packet gets its own correct result.
- rst asserted mid-packet (beat 2 of 4) → all outputs 0 the next cycle, FSM in IDLE, lu_pkt_cnt=0.
